// File: rtl/rv64_lsu.sv
`default_nettype none
// ============================================================================
// Module   : rv64_lsu
// Brief    : RV64I load/store unit towards a dword-wide synchronous-read data
//            memory. Lane extraction/extension for loads, read-modify-write
//            for sub-dword stores, misaligned/illegal requests answered as
//            errors. Optional macro LSU_BOUNDS_CHECK_EN turns out-of-range
//            addresses into errors instead of wrapping the dword index.
// Revision : 1.0 - initial release
// ============================================================================
module rv64_lsu #(
    parameter int          MEM_DWORDS = 4096,
    parameter logic [63:0] BASE_ADDR  = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [63:0] mem_rd_data,
    output logic        mem_wr_en,
    output logic [63:0] mem_wr_data
);

    localparam logic [2:0] c_s_idle   = 3'd0;
    localparam logic [2:0] c_s_ld_rd  = 3'd1;
    localparam logic [2:0] c_s_ld_cap = 3'd2;
    localparam logic [2:0] c_s_st_wr  = 3'd3;
    localparam logic [2:0] c_s_rmw_rd = 3'd4;
    localparam logic [2:0] c_s_rmw_wr = 3'd5;
    localparam logic [2:0] c_s_resp   = 3'd6;

    localparam logic [63:0] c_depth = 64'(MEM_DWORDS);

    logic [2:0]  r_state;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [63:0] r_resp_rdata;
    logic        r_rd_en;
    logic        r_wr_en;
    logic [63:0] r_mem_addr;
    logic [2:0]  r_funct3;
    logic [2:0]  r_off;
    logic [63:0] r_wdata;

    logic        w_accept;
    logic [63:0] w_idx;
    logic        w_misalign;
    logic        w_illegal;
    logic        w_oob;
    logic        w_err;
    logic [63:0] w_lane;
    logic [63:0] w_ext;
    logic [7:0]  w_bmask;
    logic [63:0] w_bitmask;
    logic [63:0] w_wsh;
    logic [63:0] w_merged;

    assign w_accept = req_valid & r_req_ready;
    assign w_idx    = {3'b000, req_addr[63:3]} - {3'b000, BASE_ADDR[63:3]};

    always_comb begin
        w_misalign = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_misalign = req_addr[0];
            2'b10:   w_misalign = |req_addr[1:0];
            2'b11:   w_misalign = |req_addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_illegal = (req_funct3 == 3'b111) | (req_we & req_funct3[2]);

`ifdef LSU_BOUNDS_CHECK_EN
    assign w_oob = (req_addr < BASE_ADDR) | (w_idx >= c_depth);
`else
    assign w_oob = 1'b0;
`endif

    assign w_err = w_misalign | w_illegal | w_oob;

    // Load path: bring the addressed lane down to bit 0, then size/extend.
    assign w_lane = mem_rd_data >> {r_off, 3'b000};

    always_comb begin
        w_ext = w_lane;
        case (r_funct3)
            3'b000:  w_ext = {{56{w_lane[7]}},  w_lane[7:0]};
            3'b001:  w_ext = {{48{w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_ext = {{32{w_lane[31]}}, w_lane[31:0]};
            3'b100:  w_ext = {56'h0, w_lane[7:0]};
            3'b101:  w_ext = {48'h0, w_lane[15:0]};
            3'b110:  w_ext = {32'h0, w_lane[31:0]};
            default: w_ext = w_lane;
        endcase
    end

    // Store path: byte-enable mask placed at the access offset, little-endian.
    always_comb begin
        w_bmask = 8'hFF;
        case (r_funct3[1:0])
            2'b00:   w_bmask = 8'h01 << r_off;
            2'b01:   w_bmask = 8'h03 << r_off;
            2'b10:   w_bmask = 8'h0F << r_off;
            default: w_bmask = 8'hFF;
        endcase
        w_bitmask = 64'h0;
        for (int i = 0; i < 8; i++) begin
            w_bitmask[8*i +: 8] = {8{w_bmask[i]}};
        end
    end

    assign w_wsh    = r_wdata << {r_off, 3'b000};
    assign w_merged = (mem_rd_data & ~w_bitmask) | (w_wsh & w_bitmask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_s_idle;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 64'h0;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_mem_addr   <= 64'h0;
            r_funct3     <= 3'b000;
            r_off        <= 3'b000;
            r_wdata      <= 64'h0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_funct3    <= req_funct3;
                        r_off       <= req_addr[2:0];
                        r_wdata     <= req_wdata;
                        if (w_err) begin
                            r_state      <= c_s_resp;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_mem_addr <= w_idx % c_depth;
                            if (!req_we) begin
                                r_state <= c_s_ld_rd;
                                r_rd_en <= 1'b1;
                            end else if (req_funct3 == 3'b011) begin
                                r_state <= c_s_st_wr;
                                r_wr_en <= 1'b1;
                            end else begin
                                r_state <= c_s_rmw_rd;
                                r_rd_en <= 1'b1;
                            end
                        end
                    end
                end
                c_s_ld_rd: begin
                    r_rd_en <= 1'b0;
                    r_state <= c_s_ld_cap;
                end
                c_s_ld_cap: begin
                    r_resp_rdata <= w_ext;
                    r_resp_valid <= 1'b1;
                    r_state      <= c_s_resp;
                end
                c_s_st_wr: begin
                    r_wr_en      <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= c_s_resp;
                end
                c_s_rmw_rd: begin
                    r_rd_en <= 1'b0;
                    r_wr_en <= 1'b1;
                    r_state <= c_s_rmw_wr;
                end
                c_s_rmw_wr: begin
                    r_wr_en      <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= c_s_resp;
                end
                c_s_resp: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 64'h0;
                    r_req_ready  <= 1'b1;
                    r_state      <= c_s_idle;
                end
                default: begin
                    r_rd_en     <= 1'b0;
                    r_wr_en     <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= c_s_idle;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign mem_addr   = r_mem_addr;
    // Gating with rst keeps an interrupted RMW from committing its write.
    assign mem_rd_en  = r_rd_en & ~rst;
    assign mem_wr_en  = r_wr_en & ~rst;
    // Read data only becomes valid in RMW_WR, so the merge stays combinational.
    assign mem_wr_data = (r_state == c_s_rmw_wr) ? w_merged :
                         (r_state == c_s_st_wr)  ? r_wdata  : 64'h0;

endmodule
`default_nettype wire

// File: tb/tb_rv64_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv64_lsu
// Brief    : Directed scoreboard bench for rv64_lsu with a behavioural
//            synchronous-read dword memory; honours LSU_BOUNDS_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv64_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [63:0] req_addr = 64'h0;
    logic [63:0] req_wdata = 64'h0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_addr;
    logic        mem_rd_en;
    logic [63:0] mem_rd_data;
    logic        mem_wr_en;
    logic [63:0] mem_wr_data;

    logic [63:0] mem [0:4095];

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [63:0] addr;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rv64_lsu #(.MEM_DWORDS(4096), .BASE_ADDR(64'h0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
    );

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr[11:0]];
        if (mem_wr_en) mem[mem_addr[11:0]] <= mem_wr_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] rdata, input logic err, input int lat,
                        input int nrd, input int nwr, input logic [63:0] addr);
        exp_t e;
        e.rdata = rdata; e.err = err; e.lat = lat;
        e.nrd = nrd; e.nwr = nwr; e.addr = addr;
        q.push_back(e);
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd);
        int k;
        @(negedge clk);
        drive(we, f3, a, wd);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("accept_ready", {63'h0, req_ready}, 64'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Watches the DUT from the cycle after the accept edge and scores one response.
    task automatic collect();
        exp_t e;
        int lat, nrd, nwr, rdc, wrc;
        logic [63:0] sa;
        lat = 0; nrd = 0; nwr = 0; rdc = -1; wrc = -1; sa = 64'h0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_rd_en) begin nrd++; rdc = c; sa = mem_addr; end
            if (mem_wr_en) begin nwr++; wrc = c; sa = mem_addr; end
            if (resp_valid) begin lat = c; break; end
        end
        if (q.size() == 0) begin
            n_vec++; n_err++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = q.pop_front();
        chk("latency", 64'(lat), 64'(e.lat));
        chk("rdata", resp_rdata, e.rdata);
        chk("err", {63'h0, resp_err}, {63'h0, e.err});
        chk("rd_pulses", 64'(nrd), 64'(e.nrd));
        chk("wr_pulses", 64'(nwr), 64'(e.nwr));
        chk("busy_ready", {63'h0, req_ready}, 64'h0);
        if (e.nrd == 1 && e.nwr == 1) chk("rmw_order", 64'(wrc), 64'(rdc + 1));
        if (e.nrd + e.nwr > 0) chk("mem_addr", sa, e.addr);
        @(negedge clk);
        chk("resp_pulse", {63'h0, resp_valid}, 64'h0);
        chk("ready_idle", {63'h0, req_ready}, 64'h1);
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] rdata, input logic err,
                        input int lat, input int nrd, input int nwr, input logic [63:0] addr);
        push(rdata, err, lat, nrd, nwr, addr);
        issue(we, f3, a, wd);
        collect();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_valid", {63'h0, resp_valid}, 64'h0);
        chk("rst_err", {63'h0, resp_err}, 64'h0);
        chk("rst_rdata", resp_rdata, 64'h0);
        chk("rst_rd_en", {63'h0, mem_rd_en}, 64'h0);
        chk("rst_wr_en", {63'h0, mem_wr_en}, 64'h0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_wr_data", mem_wr_data, 64'h0);
        rst = 1'b0;

        // Full dword store and readback
        xact(1, 3'b011, 64'h1100, 64'h0123456789ABCDEF, 64'h0, 0, 2, 0, 1, 64'h220);
        chk("sd_mem", mem[12'h220], 64'h0123456789ABCDEF);
        xact(0, 3'b011, 64'h1100, 64'h0, 64'h0123456789ABCDEF, 0, 3, 1, 0, 64'h220);

        // Lane extraction and extension
        xact(0, 3'b000, 64'h1100, 64'h0, 64'hFFFFFFFFFFFFFFEF, 0, 3, 1, 0, 64'h220);
        xact(0, 3'b100, 64'h1100, 64'h0, 64'h00000000000000EF, 0, 3, 1, 0, 64'h220);
        xact(0, 3'b000, 64'h1107, 64'h0, 64'h0000000000000001, 0, 3, 1, 0, 64'h220);
        xact(0, 3'b010, 64'h1100, 64'h0, 64'hFFFFFFFF89ABCDEF, 0, 3, 1, 0, 64'h220);
        xact(0, 3'b110, 64'h1100, 64'h0, 64'h0000000089ABCDEF, 0, 3, 1, 0, 64'h220);
        xact(0, 3'b010, 64'h1104, 64'h0, 64'h0000000001234567, 0, 3, 1, 0, 64'h220);
        xact(0, 3'b001, 64'h1100, 64'h0, 64'hFFFFFFFFFFFFCDEF, 0, 3, 1, 0, 64'h220);
        xact(0, 3'b101, 64'h1106, 64'h0, 64'h0000000000000123, 0, 3, 1, 0, 64'h220);

        // Halfword read-modify-write
        xact(1, 3'b001, 64'h1102, 64'h1234BEEF, 64'h0, 0, 3, 1, 1, 64'h220);
        chk("sh_mem", mem[12'h220], 64'h01234567BEEFCDEF);

        // Misaligned and illegal requests
        xact(0, 3'b010, 64'h1102, 64'h0, 64'h0, 1, 1, 0, 0, 64'h0);
        xact(1, 3'b100, 64'h1100, 64'h55, 64'h0, 1, 1, 0, 0, 64'h0);
        xact(0, 3'b111, 64'h1100, 64'h0, 64'h0, 1, 1, 0, 0, 64'h0);
        xact(1, 3'b010, 64'h1101, 64'h77, 64'h0, 1, 1, 0, 0, 64'h0);
        xact(0, 3'b011, 64'h1104, 64'h0, 64'h0, 1, 1, 0, 0, 64'h0);
        xact(0, 3'b101, 64'h1101, 64'h0, 64'h0, 1, 1, 0, 0, 64'h0);
        chk("err_mem", mem[12'h220], 64'h01234567BEEFCDEF);

        // Reset during RMW_WR must abort without a write or response
        issue(1, 3'b000, 64'h1100, 64'hAA);
        @(negedge clk);
        chk("abort_rd_en", {63'h0, mem_rd_en}, 64'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_wr_en", {63'h0, mem_wr_en}, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", {63'h0, req_ready}, 64'h1);
        chk("abort_valid", {63'h0, resp_valid}, 64'h0);
        repeat (3) @(negedge clk);
        chk("abort_no_resp", {63'h0, resp_valid}, 64'h0);
        chk("abort_mem", mem[12'h220], 64'h01234567BEEFCDEF);

        // Byte and word merges at non-zero offsets
        xact(1, 3'b000, 64'h1101, 64'hFFFFFF5A, 64'h0, 0, 3, 1, 1, 64'h220);
        chk("sb_mem", mem[12'h220], 64'h01234567BEEF5AEF);
        xact(1, 3'b010, 64'h1104, 64'h11223344CAFEF00D, 64'h0, 0, 3, 1, 1, 64'h220);
        chk("sw_mem", mem[12'h220], 64'hCAFEF00DBEEF5AEF);
        xact(0, 3'b010, 64'h1104, 64'h0, 64'hFFFFFFFFCAFEF00D, 0, 3, 1, 0, 64'h220);

        // Held request while busy is only taken after RESP
        push(64'hCAFEF00DBEEF5AEF, 0, 3, 1, 0, 64'h220);
        push(64'h00000000000000CA, 0, 3, 1, 0, 64'h220);
        @(negedge clk);
        drive(0, 3'b011, 64'h1100, 64'h0);
        chk("b2b_ready", {63'h0, req_ready}, 64'h1);
        @(posedge clk);
        #1 drive(0, 3'b100, 64'h1107, 64'h0);
        collect();
        @(posedge clk);
        #1 req_valid = 1'b0;
        collect();

        // Address range handling
        xact(1, 3'b011, 64'h0, 64'hDEADBEEF0BADF00D, 64'h0, 0, 2, 0, 1, 64'h0);
`ifdef LSU_BOUNDS_CHECK_EN
        xact(0, 3'b011, 64'h8000, 64'h0, 64'h0, 1, 1, 0, 0, 64'h0);
`else
        xact(0, 3'b011, 64'h8000, 64'h0, 64'hDEADBEEF0BADF00D, 0, 3, 1, 0, 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
